// File: rtl/slc3_panel_input.sv
// slc3_panel_input
//   Board-side conditioning of the SLC-3 front panel. The active-low Run and
//   Continue keys each pass through a 2-flop synchronizer and a debounce FSM
//   that produces a held level and a one-cycle press strobe. Continue also
//   drives a sticky request that stays up until the CPU acknowledges it. The
//   slide switches are only synchronized.
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous, active-high
//   Run        in   raw Run key, active-low, asynchronous
//   Continue   in   raw Continue key, active-low, asynchronous
//   SW         in   raw slide switches, asynchronous
//   sw_sync    out  SW after the 2-flop synchronizer
//   run_held   out  debounced Run level, 1 = pressed
//   run_pulse  out  one-cycle strobe on a debounced Run press
//   cont_held  out  debounced Continue level, 1 = pressed
//   cont_pulse out  one-cycle strobe on a debounced Continue press
//   cont_req   out  sticky Continue request
//   cont_ack   in   CPU consumed the request; clears cont_req

// slc3_panel_key
//   One key: synchronizer plus debounce FSM. Returns next-state decodes so the
//   parent registers the outputs on the same edge the FSM moves.
//
//   state           | meaning
//   ST_RELEASED     | key stable released
//   ST_PRESS_PEND   | synced level low, counting toward a confirmed press
//   ST_PRESSED      | key stable pressed
//   ST_RELEASE_PEND | synced level high, counting toward a confirmed release
//
// Ports
//   clk_i, rst_i    clock and synchronous active-high reset
//   key_n_i         raw active-low key
//   held_next_o     FSM will be in PRESSED/RELEASE_PEND after this edge
//   press_o         this edge enters PRESSED from RELEASED/PRESS_PEND
module slc3_panel_key #(
   parameter int DEBOUNCE_CYCLES = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_n_i,
   output logic held_next_o,
   output logic press_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] D_CNT = CW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      ST_RELEASED,
      ST_PRESS_PEND,
      ST_PRESSED,
      ST_RELEASE_PEND
   } key_state_e;

   key_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic            s1_q, s2_q;

   assign cnt_inc = cnt_q + 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         state_q <= ST_RELEASED;
         cnt_q   <= '0;
      end else begin
         s1_q    <= key_n_i;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RELEASED: begin
            if (!s2_q) begin
               // A single confirming sample is already enough when D is 1.
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = ST_PRESSED;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_PRESS_PEND;
                  cnt_d   = CW'(1);
               end
            end
         end
         ST_PRESS_PEND: begin
            if (s2_q) begin
               state_d = ST_RELEASED;
               cnt_d   = '0;
            end else if (cnt_inc == D_CNT) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_PRESSED: begin
            if (s2_q) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = ST_RELEASED;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_RELEASE_PEND;
                  cnt_d   = CW'(1);
               end
            end
         end
         ST_RELEASE_PEND: begin
            if (!s2_q) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
            end else if (cnt_inc == D_CNT) begin
               state_d = ST_RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   // Returning to PRESSED from RELEASE_PEND is release bounce, not a new press.
   assign press_o     = (state_d == ST_PRESSED) &&
                        ((state_q == ST_RELEASED) || (state_q == ST_PRESS_PEND));
   assign held_next_o = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_PEND);
endmodule

module slc3_panel_input #(
   parameter int DEBOUNCE_CYCLES = 1,
   parameter int SW_WIDTH        = 10
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                Run,
   input  logic                Continue,
   input  logic [SW_WIDTH-1:0] SW,
   output logic [SW_WIDTH-1:0] sw_sync,
   output logic                run_held,
   output logic                run_pulse,
   output logic                cont_held,
   output logic                cont_pulse,
   output logic                cont_req,
   input  logic                cont_ack
);
   logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q;
   logic run_held_q, run_pulse_q, cont_held_q, cont_pulse_q, cont_req_q;
   logic run_held_d, run_press, cont_held_d, cont_press, cont_req_d;

   slc3_panel_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
      .clk_i       (Clk),
      .rst_i       (Reset),
      .key_n_i     (Run),
      .held_next_o (run_held_d),
      .press_o     (run_press)
   );

   slc3_panel_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cont_key (
      .clk_i       (Clk),
      .rst_i       (Reset),
      .key_n_i     (Continue),
      .held_next_o (cont_held_d),
      .press_o     (cont_press)
   );

   // A new press wins over a same-edge acknowledge so it is never lost.
   always_comb begin
      cont_req_d = cont_req_q;
      if (cont_press) begin
         cont_req_d = 1'b1;
      end else if (cont_ack) begin
         cont_req_d = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sw_s1_q      <= '0;
         sw_s2_q      <= '0;
         run_held_q   <= 1'b0;
         run_pulse_q  <= 1'b0;
         cont_held_q  <= 1'b0;
         cont_pulse_q <= 1'b0;
         cont_req_q   <= 1'b0;
      end else begin
         sw_s1_q      <= SW;
         sw_s2_q      <= sw_s1_q;
         run_held_q   <= run_held_d;
         run_pulse_q  <= run_press;
         cont_held_q  <= cont_held_d;
         cont_pulse_q <= cont_press;
         cont_req_q   <= cont_req_d;
      end
   end

   assign sw_sync    = sw_s2_q;
   assign run_held   = run_held_q;
   assign run_pulse  = run_pulse_q;
   assign cont_held  = cont_held_q;
   assign cont_pulse = cont_pulse_q;
   assign cont_req   = cont_req_q;
endmodule

// File: tb/tb_slc3_panel_input.sv
module tb_slc3_panel_input;
   logic       clk = 1'b0;
   logic       rst;
   logic       run1, cont1, ack1;
   logic       run4, cont4, ack4;
   logic [9:0] sw;
   logic [9:0] sw_sync1, sw_sync4;
   logic       run_held1, run_pulse1, cont_held1, cont_pulse1, cont_req1;
   logic       run_held4, run_pulse4, cont_held4, cont_pulse4, cont_req4;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   slc3_panel_input #(.DEBOUNCE_CYCLES(1), .SW_WIDTH(10)) u_d1 (
      .Clk(clk), .Reset(rst), .Run(run1), .Continue(cont1), .SW(sw),
      .sw_sync(sw_sync1), .run_held(run_held1), .run_pulse(run_pulse1),
      .cont_held(cont_held1), .cont_pulse(cont_pulse1), .cont_req(cont_req1),
      .cont_ack(ack1)
   );

   slc3_panel_input #(.DEBOUNCE_CYCLES(4), .SW_WIDTH(10)) u_d4 (
      .Clk(clk), .Reset(rst), .Run(run4), .Continue(cont4), .SW(sw),
      .sw_sync(sw_sync4), .run_held(run_held4), .run_pulse(run_pulse4),
      .cont_held(cont_held4), .cont_pulse(cont_pulse4), .cont_req(cont_req4),
      .cont_ack(ack4)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [11:0] outs;
      rst = 1'b1; run1 = 1'b1; cont1 = 1'b1; run4 = 1'b1; cont4 = 1'b1;
      ack1 = 1'b0; ack4 = 1'b0; sw = 10'h05A;
      repeat (3) tick();
      outs = {run_held1, run_pulse1, cont_held1, cont_pulse1, cont_req1,
              run_held4, run_pulse4, cont_held4, cont_pulse4, cont_req4, 2'b00};
      n_tests++;
      if (outs !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_outputs got %h want 000", outs);
      end
      n_tests++;
      if (sw_sync1 !== 10'h000 || sw_sync4 !== 10'h000) begin
         n_fail++;
         $display("FAIL reset_sw got %h/%h want 000", sw_sync1, sw_sync4);
      end
      rst = 1'b0;
      tick();
      n_tests++;
      if (sw_sync1 !== 10'h000) begin
         n_fail++;
         $display("FAIL sw_first_edge got %h want 000", sw_sync1);
      end
      tick();
      n_tests++;
      if (sw_sync1 !== 10'h05A || sw_sync4 !== 10'h05A) begin
         n_fail++;
         $display("FAIL sw_second_edge got %h/%h want 05a", sw_sync1, sw_sync4);
      end
   endtask

   task automatic test_sw;
      sw = 10'h3A5;
      tick();
      n_tests++;
      if (sw_sync1 !== 10'h05A) begin
         n_fail++;
         $display("FAIL sw_latency1 got %h want 05a", sw_sync1);
      end
      tick();
      n_tests++;
      if (sw_sync1 !== 10'h3A5) begin
         n_fail++;
         $display("FAIL sw_latency2 got %h want 3a5", sw_sync1);
      end
   endtask

   // D=1, Run low for one sampled edge k: pulse and held only after edge k+2.
   task automatic test_run_pulse_d1;
      logic [1:0] exp;
      for (int i = 0; i < 6; i++) begin
         run1 = (i == 0) ? 1'b0 : 1'b1;
         tick();
         exp = (i == 2) ? 2'b11 : 2'b00;
         n_tests++;
         if ({run_held1, run_pulse1} !== exp) begin
            n_fail++;
            $display("FAIL run_d1 i=%0d held,pulse got %b want %b", i, {run_held1, run_pulse1}, exp);
         end
      end
   endtask

   task automatic test_cont_hold_d1;
      int npulse = 0;
      int nheld  = 0;
      for (int i = 0; i < 105; i++) begin
         cont1 = (i < 100) ? 1'b0 : 1'b1;
         tick();
         if (cont_pulse1 === 1'b1) npulse++;
         if (cont_held1 === 1'b1) nheld++;
      end
      n_tests++;
      if (npulse != 1) begin
         n_fail++;
         $display("FAIL cont_hold_pulses got %0d want 1", npulse);
      end
      n_tests++;
      if (nheld != 100) begin
         n_fail++;
         $display("FAIL cont_hold_held got %0d want 100", nheld);
      end
      n_tests++;
      if (cont_req1 !== 1'b1) begin
         n_fail++;
         $display("FAIL cont_req_before_ack got %b want 1", cont_req1);
      end
      ack1 = 1'b1;
      tick();
      ack1 = 1'b0;
      n_tests++;
      if (cont_req1 !== 1'b0) begin
         n_fail++;
         $display("FAIL cont_req_after_ack got %b want 0", cont_req1);
      end
   endtask

   // D=4: short glitch ignored; 4-cycle press pulses after k+5; release bounce
   // returns to PRESSED without a second pulse; release confirmed at k+13.
   task automatic test_run_debounce_d4;
      logic [1:0] exp;
      for (int i = 0; i < 12; i++) begin
         run4 = (i < 3) ? 1'b0 : 1'b1;
         tick();
         n_tests++;
         if ({run_held4, run_pulse4} !== 2'b00) begin
            n_fail++;
            $display("FAIL run_d4_glitch i=%0d held,pulse got %b want 00", i, {run_held4, run_pulse4});
         end
      end
      for (int i = 0; i < 18; i++) begin
         run4 = (i <= 3 || i == 6 || i == 7) ? 1'b0 : 1'b1;
         tick();
         exp = {(i >= 5 && i <= 12), (i == 5)};
         n_tests++;
         if ({run_held4, run_pulse4} !== exp) begin
            n_fail++;
            $display("FAIL run_d4_press i=%0d held,pulse got %b want %b", i, {run_held4, run_pulse4}, exp);
         end
      end
   endtask

   task automatic test_cont_ack_race;
      for (int i = 0; i < 6; i++) begin
         cont1 = (i == 0) ? 1'b0 : 1'b1;
         tick();
      end
      n_tests++;
      if (cont_req1 !== 1'b1) begin
         n_fail++;
         $display("FAIL race_req_first got %b want 1", cont_req1);
      end
      for (int i = 0; i < 6; i++) begin
         cont1 = (i == 0) ? 1'b0 : 1'b1;
         ack1  = (i == 2) ? 1'b1 : 1'b0;
         tick();
         if (i == 2) begin
            n_tests++;
            if ({cont_pulse1, cont_req1} !== 2'b11) begin
               n_fail++;
               $display("FAIL race_set_wins pulse,req got %b want 11", {cont_pulse1, cont_req1});
            end
         end
      end
      ack1 = 1'b0;
      n_tests++;
      if (cont_req1 !== 1'b1) begin
         n_fail++;
         $display("FAIL race_req_hold got %b want 1", cont_req1);
      end
      ack1 = 1'b1;
      tick();
      n_tests++;
      if (cont_req1 !== 1'b0) begin
         n_fail++;
         $display("FAIL race_ack_clear got %b want 0", cont_req1);
      end
      tick();
      ack1 = 1'b0;
      n_tests++;
      if (cont_req1 !== 1'b0) begin
         n_fail++;
         $display("FAIL race_ack_idle got %b want 0", cont_req1);
      end
   endtask

   // D=4: Reset hits while Continue is in PRESS_PEND and stays low.
   task automatic test_reset_in_pend;
      logic [2:0] exp;
      cont4 = 1'b0;
      repeat (4) tick();
      n_tests++;
      if ({cont_held4, cont_pulse4} !== 2'b00) begin
         n_fail++;
         $display("FAIL pend_not_held held,pulse got %b want 00", {cont_held4, cont_pulse4});
      end
      rst = 1'b1;
      repeat (2) tick();
      n_tests++;
      if ({cont_held4, cont_pulse4, cont_req4, cont_req1} !== 4'b0000) begin
         n_fail++;
         $display("FAIL pend_reset got %b want 0000", {cont_held4, cont_pulse4, cont_req4, cont_req1});
      end
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         exp = {(i >= 5), (i == 5), (i >= 5)};
         n_tests++;
         if ({cont_held4, cont_pulse4, cont_req4} !== exp) begin
            n_fail++;
            $display("FAIL pend_after_reset i=%0d held,pulse,req got %b want %b", i, {cont_held4, cont_pulse4, cont_req4}, exp);
         end
      end
      cont4 = 1'b1;
   endtask

   initial begin
      test_reset();
      test_sw();
      test_run_pulse_d1();
      test_cont_hold_d1();
      test_run_debounce_d4();
      test_cont_ack_race();
      test_reset_in_pend();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
